// File: rtl/msx_reset_sequencer_if.sv
// Reset-sequencer signal bundle: PLL lock and reset requests in, ordered reset levels and status out.
// The master side drives the requests; the slave modport belongs to msx_reset_sequencer.
interface msx_reset_sequencer_if;
    logic       pll_locked;
    logic       req_cold;
    logic       req_warm;
    logic       cold_reset;
    logic       warm_reset;
    logic       rtc_setup;
    logic       ready;
    logic [1:0] reset_cause;

    modport master (
        output pll_locked, req_cold, req_warm,
        input  cold_reset, warm_reset, rtc_setup, ready, reset_cause
    );

    modport slave (
        input  pll_locked, req_cold, req_warm,
        output cold_reset, warm_reset, rtc_setup, ready, reset_cause
    );
endinterface

// File: rtl/msx_reset_sequencer.sv
// MSX reset sequencer: merges PLL lock, power-on delay and cold/warm requests into POR->COLD->(RTC)->RUN.
// Optional feature macro MSX_RESET_RTC_SETUP_EN adds the RTC load state between COLD and RUN.
module msx_reset_sequencer #(
    parameter int POR_CYCLES  = 5000000,
    parameter int HOLD_CYCLES = 1024,
    parameter int RTC_CYCLES  = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    msx_reset_sequencer_if.slave  bus
);

    localparam int MAX_CYCLES = (POR_CYCLES > HOLD_CYCLES)
                              ? ((POR_CYCLES > RTC_CYCLES) ? POR_CYCLES : RTC_CYCLES)
                              : ((HOLD_CYCLES > RTC_CYCLES) ? HOLD_CYCLES : RTC_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef MSX_RESET_RTC_SETUP_EN
    localparam logic [CW-1:0] RTC_LAST  = CW'(RTC_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_POR  = 3'd0,
        ST_COLD = 3'd1,
        ST_WARM = 3'd2,
        ST_RUN  = 3'd3
`ifdef MSX_RESET_RTC_SETUP_EN
        , ST_RTC = 3'd4
`endif
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [1:0]    cause_r;
    logic [1:0]    cause_nxt_s;
    logic          req_cold_d_r;
    logic          req_warm_d_r;
    logic          cold_hold_s;
    logic          warm_hold_s;
    logic [2:0]    levels_s;
    logic          cold_r;
    logic          warm_r;
    logic          ready_r;

    // {cold_reset, warm_reset, ready} for each state
    function automatic logic [2:0] decode_levels(input state_t s);
        case (s)
            ST_POR:  decode_levels = 3'b110;
            ST_COLD: decode_levels = 3'b110;
            ST_WARM: decode_levels = 3'b010;
            ST_RUN:  decode_levels = 3'b001;
`ifdef MSX_RESET_RTC_SETUP_EN
            ST_RTC:  decode_levels = 3'b010;
`endif
            default: decode_levels = 3'b110;
        endcase
    endfunction

    // The edge on which a request is first seen low still pins the counter, so the
    // hold window of HOLD_CYCLES starts only after the request has been released.
    assign cold_hold_s = bus.req_cold | req_cold_d_r;
    assign warm_hold_s = bus.req_warm | req_warm_d_r;

    // Next-state, sequence counter and reset-cause selection
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        cause_nxt_s = cause_r;
        if (!bus.pll_locked) begin
            state_nxt_s = ST_POR;
            count_nxt_s = '0;
            if (state_r == ST_RUN) begin
                cause_nxt_s = 2'd3;
            end else begin
                cause_nxt_s = cause_r;
            end
        end else begin
            case (state_r)
                ST_POR: begin
                    if (count_r == POR_LAST) begin
                        state_nxt_s = ST_COLD;
                        count_nxt_s = '0;
                    end else begin
                        count_nxt_s = count_r + 1'b1;
                    end
                end
                ST_COLD: begin
                    if (cold_hold_s) begin
                        count_nxt_s = '0;
                    end else if (count_r == HOLD_LAST) begin
`ifdef MSX_RESET_RTC_SETUP_EN
                        state_nxt_s = ST_RTC;
`else
                        state_nxt_s = ST_RUN;
`endif
                        count_nxt_s = '0;
                    end else begin
                        count_nxt_s = count_r + 1'b1;
                    end
                end
`ifdef MSX_RESET_RTC_SETUP_EN
                ST_RTC: begin
                    if (bus.req_cold) begin
                        state_nxt_s = ST_COLD;
                        count_nxt_s = '0;
                    end else if (count_r == RTC_LAST) begin
                        state_nxt_s = ST_RUN;
                        count_nxt_s = '0;
                    end else begin
                        count_nxt_s = count_r + 1'b1;
                    end
                end
`endif
                ST_WARM: begin
                    if (bus.req_cold) begin
                        state_nxt_s = ST_COLD;
                        count_nxt_s = '0;
                    end else if (warm_hold_s) begin
                        count_nxt_s = '0;
                    end else if (count_r == HOLD_LAST) begin
                        state_nxt_s = ST_RUN;
                        count_nxt_s = '0;
                    end else begin
                        count_nxt_s = count_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.req_cold) begin
                        state_nxt_s = ST_COLD;
                        count_nxt_s = '0;
                        cause_nxt_s = 2'd1;
                    end else if (bus.req_warm) begin
                        state_nxt_s = ST_WARM;
                        count_nxt_s = '0;
                        cause_nxt_s = 2'd2;
                    end else begin
                        count_nxt_s = '0;
                    end
                end
                default: begin
                    state_nxt_s = ST_POR;
                    count_nxt_s = '0;
                end
            endcase
        end
    end

    assign levels_s = decode_levels(state_nxt_s);

    // State, counter, request history and registered output levels
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_POR;
            count_r      <= '0;
            cause_r      <= 2'd0;
            req_cold_d_r <= 1'b0;
            req_warm_d_r <= 1'b0;
            cold_r       <= 1'b1;
            warm_r       <= 1'b1;
            ready_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            cause_r      <= cause_nxt_s;
            req_cold_d_r <= bus.req_cold;
            req_warm_d_r <= bus.req_warm;
            cold_r       <= levels_s[2];
            warm_r       <= levels_s[1];
            ready_r      <= levels_s[0];
        end
    end

`ifdef MSX_RESET_RTC_SETUP_EN
    logic rtc_r;

    // RTC load strobe, high for the whole RTC state
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rtc_r <= 1'b0;
        end else begin
            rtc_r <= (state_nxt_s == ST_RTC);
        end
    end

    assign bus.rtc_setup = rtc_r;
`else
    assign bus.rtc_setup = 1'b0;
`endif

    assign bus.cold_reset  = cold_r;
    assign bus.warm_reset  = warm_r;
    assign bus.ready       = ready_r;
    assign bus.reset_cause = cause_r;

endmodule

// File: tb/tb_msx_reset_sequencer.sv
// Self-checking bench for msx_reset_sequencer: directed boot/request scenarios plus randomized traffic
// compared against a deadline-based reference model. Expectations follow MSX_RESET_RTC_SETUP_EN.
module tb_msx_reset_sequencer;

    localparam int POR  = 20;
    localparam int HOLD = 4;
    localparam int RTC  = 2;

    localparam int PH_BOOT = 0;
    localparam int PH_COLD = 1;
    localparam int PH_RTC  = 2;
    localparam int PH_WARM = 3;
    localparam int PH_RUN  = 4;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    msx_reset_sequencer_if bus();

    msx_reset_sequencer #(
        .POR_CYCLES  (POR),
        .HOLD_CYCLES (HOLD),
        .RTC_CYCLES  (RTC)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passed = 0;
    int edge_n = 0;

    // Reference model: phase plus edge deadlines
    int m_ph    = PH_BOOT;
    int m_n     = 0;
    int m_rel   = 0;
    int m_ent   = 0;
    int m_cause = 0;

    logic [5:0] dut_vec;
    assign dut_vec = {bus.cold_reset, bus.warm_reset, bus.rtc_setup, bus.ready, bus.reset_cause};

    function automatic logic [5:0] model_vec();
        return {(m_ph == PH_BOOT) || (m_ph == PH_COLD), m_ph != PH_RUN,
                m_ph == PH_RTC, m_ph == PH_RUN, 2'(m_cause)};
    endfunction

    // Expected levels e edges after a clean restart with lock steady and no requests
    function automatic logic [5:0] boot_vec(input int e);
        int fall = POR + HOLD;
`ifdef MSX_RESET_RTC_SETUP_EN
        int rdy = POR + HOLD + RTC;
`else
        int rdy = POR + HOLD;
`endif
        return {e < fall, e < rdy, (e >= fall) && (e < rdy), e >= rdy, 2'b00};
    endfunction

    task automatic step();
        logic lk;
        logic rc;
        logic rw;
        @(posedge clk_sys);
        lk = bus.pll_locked;
        rc = bus.req_cold;
        rw = bus.req_warm;
        edge_n++;
        if (reset) begin
            m_ph = PH_BOOT; m_n = 0; m_cause = 0;
        end else if (!lk) begin
            if (m_ph == PH_RUN) m_cause = 3;
            m_ph = PH_BOOT; m_n = 0;
        end else begin
            case (m_ph)
                PH_BOOT: begin
                    m_n++;
                    if (m_n == POR) begin
                        m_ph = PH_COLD;
                        m_rel = rc ? edge_n + 1 : edge_n;
                    end
                end
                PH_COLD: begin
                    if (rc) m_rel = edge_n + 1;
                    if (edge_n == m_rel + HOLD) begin
`ifdef MSX_RESET_RTC_SETUP_EN
                        m_ph = PH_RTC; m_ent = edge_n;
`else
                        m_ph = PH_RUN;
`endif
                    end
                end
                PH_RTC: begin
                    if (rc) begin m_ph = PH_COLD; m_rel = edge_n + 1; end
                    else if (edge_n == m_ent + RTC) m_ph = PH_RUN;
                end
                PH_WARM: begin
                    if (rc) begin m_ph = PH_COLD; m_rel = edge_n + 1; end
                    else begin
                        if (rw) m_rel = edge_n + 1;
                        if (edge_n == m_rel + HOLD) m_ph = PH_RUN;
                    end
                end
                default: begin
                    if (rc) begin m_ph = PH_COLD; m_rel = edge_n + 1; m_cause = 1; end
                    else if (rw) begin m_ph = PH_WARM; m_rel = edge_n + 1; m_cause = 2; end
                end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pll_locked = 1'b1;
        bus.req_cold = 1'b0;
        bus.req_warm = 1'b0;
        repeat (3) step();
        edge_n = 0;
        checks++;
        if (dut_vec !== 6'b110000) $display("FAIL reset_state: got %b expected %b", dut_vec, 6'b110000);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_boot();
        test_reset();
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if (dut_vec !== boot_vec(edge_n))
                $display("FAIL boot edge %0d: got %b expected %b", edge_n, dut_vec, boot_vec(edge_n));
            else passed++;
        end
    endtask

    task automatic test_lock_glitch();
        test_reset();
        while (edge_n < 10) step();
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        while (edge_n < 40) begin
            step();
            checks++;
            if (dut_vec !== boot_vec(edge_n - 11))
                $display("FAIL lock_glitch edge %0d: got %b expected %b", edge_n, dut_vec, boot_vec(edge_n - 11));
            else passed++;
        end
    endtask

    task automatic test_warm_pulse();
        int warm_cnt = 0;
        int bad_cnt = 0;
        checks++;
        if (bus.ready !== 1'b1) $display("FAIL warm_pre_ready: got %b expected 1", bus.ready);
        else passed++;
        bus.req_warm = 1'b1;
        step();
        bus.req_warm = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            if (bus.warm_reset === 1'b1) warm_cnt++;
            if (bus.cold_reset !== 1'b0 || bus.rtc_setup !== 1'b0) bad_cnt++;
        end
        checks++;
        if (warm_cnt != HOLD + 1) $display("FAIL warm_width: got %0d expected %0d", warm_cnt, HOLD + 1);
        else passed++;
        checks++;
        if (bad_cnt != 0) $display("FAIL warm_no_cold_rtc: got %0d bad cycles expected 0", bad_cnt);
        else passed++;
        checks++;
        if (dut_vec !== 6'b000110) $display("FAIL warm_after: got %b expected %b", dut_vec, 6'b000110);
        else passed++;
    endtask

    task automatic test_cold_warm_same();
        int cold_after = 0;
        int rtc_cnt = 0;
        bus.req_cold = 1'b1;
        bus.req_warm = 1'b1;
        step();
        bus.req_cold = 1'b0;
        bus.req_warm = 1'b0;
        checks++;
        if (bus.cold_reset !== 1'b1 || bus.reset_cause !== 2'd1)
            $display("FAIL both_entry: got cold=%b cause=%0d expected cold=1 cause=1", bus.cold_reset, bus.reset_cause);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.cold_reset === 1'b1) cold_after++;
            if (bus.rtc_setup === 1'b1) rtc_cnt++;
        end
        checks++;
        if (cold_after != HOLD) $display("FAIL both_cold_after_release: got %0d expected %0d", cold_after, HOLD);
        else passed++;
        checks++;
`ifdef MSX_RESET_RTC_SETUP_EN
        if (rtc_cnt != RTC) $display("FAIL both_rtc_pulse: got %0d expected %0d", rtc_cnt, RTC);
`else
        if (rtc_cnt != 0) $display("FAIL both_rtc_pulse: got %0d expected 0", rtc_cnt);
`endif
        else passed++;
        checks++;
        if (dut_vec !== 6'b000101) $display("FAIL both_after: got %b expected %b", dut_vec, 6'b000101);
        else passed++;
    endtask

    task automatic test_cold_during_warm();
        int cold_cnt = 0;
        int rtc_cnt = 0;
        int budget = 0;
        bus.req_warm = 1'b1;
        step();
        bus.req_warm = 1'b0;
        step();
        step();
        bus.req_cold = 1'b1;
        step();
        bus.req_cold = 1'b0;
        checks++;
        if (bus.cold_reset !== 1'b1) $display("FAIL warm_to_cold: got cold=%b expected 1", bus.cold_reset);
        else passed++;
        while (bus.ready !== 1'b1 && budget < 40) begin
            if (bus.cold_reset === 1'b1) cold_cnt++;
            if (bus.rtc_setup === 1'b1) rtc_cnt++;
            step();
            budget++;
        end
        checks++;
        if (bus.ready !== 1'b1) $display("FAIL warm_to_cold_ready: got %b after %0d cycles expected 1", bus.ready, budget);
        else passed++;
        checks++;
        if (cold_cnt != HOLD + 1) $display("FAIL warm_to_cold_width: got %0d expected %0d", cold_cnt, HOLD + 1);
        else passed++;
        checks++;
`ifdef MSX_RESET_RTC_SETUP_EN
        if (rtc_cnt != RTC) $display("FAIL warm_to_cold_rtc: got %0d expected %0d", rtc_cnt, RTC);
`else
        if (rtc_cnt != 0) $display("FAIL warm_to_cold_rtc: got %0d expected 0", rtc_cnt);
`endif
        else passed++;
        checks++;
        if (dut_vec !== model_vec()) $display("FAIL warm_to_cold_model: got %b expected %b", dut_vec, model_vec());
        else passed++;
    endtask

    task automatic test_random();
        int rc_left = 0;
        int rw_left = 0;
        int rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 799) == 0) rst_left = 2;
            reset = (rst_left > 0);
            bus.pll_locked = ($urandom_range(0, 249) != 0);
            if (rc_left > 0) rc_left--;
            else if ($urandom_range(0, 69) == 0) rc_left = $urandom_range(1, 6);
            if (rw_left > 0) rw_left--;
            else if ($urandom_range(0, 39) == 0) rw_left = $urandom_range(1, 8);
            bus.req_cold = (rc_left > 0);
            bus.req_warm = (rw_left > 0);
            step();
            checks++;
            if (dut_vec !== model_vec())
                $display("FAIL random edge %0d: got %b expected %b", edge_n, dut_vec, model_vec());
            else passed++;
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.pll_locked = 1'b1;
        bus.req_cold = 1'b0;
        bus.req_warm = 1'b0;
        test_boot();
        test_lock_glitch();
        test_warm_pulse();
        test_cold_warm_same();
        test_cold_during_warm();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
